// File: rtl/pwm_capture4_pkg.sv
// Constants shared by the 4-channel PWM generator and capture blocks.
// Duty N means N high cycles in a PWM_PERIOD-cycle period.
package pwm_pkg;

    localparam int DUTY_W = 8;
    localparam int PWM_PERIOD = 256;
    localparam int TIMEOUT_DFLT = 511;
    localparam int CNT_W_DFLT = 10;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;

    typedef logic [DUTY_W-1:0] duty_t;

    function automatic duty_t sat_duty(input logic [31:0] v);
        if (v > 32'(DUTY_MAX)) begin
            return DUTY_MAX;
        end
        return v[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_capture4_if.sv
// One capture channel: PWM input plus decoded duty, valid pulse and stuck flag.
interface pwm_capture4_if;
    import pwm_pkg::*;

    logic  pwm;
    duty_t duty;
    logic  valid;
    logic  stuck;

    modport master (
        output pwm,
        input  duty,
        input  valid,
        input  stuck
    );

    modport slave (
        input  pwm,
        output duty,
        output valid,
        output stuck
    );

endinterface

// File: rtl/pwm_capture4_ch.sv
// Single-channel PWM duty decoder: synchronizer, rising-edge detect,
// period/high-time counters, arm and stuck tracking, registered outputs.
module pwm_capture_ch
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = TIMEOUT_DFLT,
    parameter int CNT_W       = CNT_W_DFLT
) (
    input  logic clk,
    input  logic rst,
    pwm_capture4_if.slave ch
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   rise;
    logic                   timeout;

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             armed_q, armed_d;
    logic             stuck_q, stuck_d;
    logic             valid_q, valid_d;
    duty_t            duty_q, duty_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    // period_q is held at zero while stuck, so this fires once per stall
    assign timeout = ~rise & ~stuck_q & (period_q == TO_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ch.pwm};
            s_d_q  <= s;
        end
    end

    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        armed_d  = armed_q;
        stuck_d  = stuck_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        unique case (1'b1)
            rise: begin
                if (armed_q) begin
                    duty_d  = sat_duty(32'(high_q));
                    valid_d = 1'b1;
                end
                high_d   = CNT_ONE;
                period_d = CNT_ONE;
                armed_d  = 1'b1;
                stuck_d  = 1'b0;
            end
            timeout: begin
                duty_d   = s ? DUTY_MAX : '0;
                valid_d  = 1'b1;
                stuck_d  = 1'b1;
                armed_d  = 1'b0;
                period_d = '0;
                high_d   = '0;
            end
            default: begin
                if (!stuck_q && period_q != CNT_MAX) begin
                    period_d = period_q + 1'b1;
                end
                if (s && high_q != CNT_MAX) begin
                    high_d = high_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            high_q   <= '0;
            armed_q  <= 1'b0;
            stuck_q  <= 1'b0;
            valid_q  <= 1'b0;
            duty_q   <= '0;
        end else begin
            period_q <= period_d;
            high_q   <= high_d;
            armed_q  <= armed_d;
            stuck_q  <= stuck_d;
            valid_q  <= valid_d;
            duty_q   <= duty_d;
        end
    end

    assign ch.duty  = duty_q;
    assign ch.valid = valid_q;
    assign ch.stuck = stuck_q;

endmodule

// File: rtl/pwm_capture4.sv
// Four independent PWM duty decoders; the top level is wiring only.
module pwm_capture4
    import pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = TIMEOUT_DFLT,
    parameter int CNT_W       = CNT_W_DFLT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  pwm_in_ch0,
    input  logic  pwm_in_ch1,
    input  logic  pwm_in_ch2,
    input  logic  pwm_in_ch3,
    output duty_t duty_ch0,
    output duty_t duty_ch1,
    output duty_t duty_ch2,
    output duty_t duty_ch3,
    output logic  duty_valid_ch0,
    output logic  duty_valid_ch1,
    output logic  duty_valid_ch2,
    output logic  duty_valid_ch3,
    output logic  stuck_ch0,
    output logic  stuck_ch1,
    output logic  stuck_ch2,
    output logic  stuck_ch3
);

    pwm_capture4_if u_if0 ();
    pwm_capture4_if u_if1 ();
    pwm_capture4_if u_if2 ();
    pwm_capture4_if u_if3 ();

    assign u_if0.pwm = pwm_in_ch0;
    assign u_if1.pwm = pwm_in_ch1;
    assign u_if2.pwm = pwm_in_ch2;
    assign u_if3.pwm = pwm_in_ch3;

    assign duty_ch0 = u_if0.duty;
    assign duty_ch1 = u_if1.duty;
    assign duty_ch2 = u_if2.duty;
    assign duty_ch3 = u_if3.duty;

    assign duty_valid_ch0 = u_if0.valid;
    assign duty_valid_ch1 = u_if1.valid;
    assign duty_valid_ch2 = u_if2.valid;
    assign duty_valid_ch3 = u_if3.valid;

    assign stuck_ch0 = u_if0.stuck;
    assign stuck_ch1 = u_if1.stuck;
    assign stuck_ch2 = u_if2.stuck;
    assign stuck_ch3 = u_if3.stuck;

    pwm_capture_ch #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_ch0 (.clk(clk), .rst(rst), .ch(u_if0));

    pwm_capture_ch #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_ch1 (.clk(clk), .rst(rst), .ch(u_if1));

    pwm_capture_ch #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_ch2 (.clk(clk), .rst(rst), .ch(u_if2));

    pwm_capture_ch #(
        .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_ch3 (.clk(clk), .rst(rst), .ch(u_if3));

endmodule

// File: tb/tb_pwm_capture4.sv
// Testbench for pwm_capture4: per-channel waveform generators push the
// expected duty on each driven rising edge; tasks pop and compare.
module tb_pwm_capture4;
    import pwm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] pwm = '0;

    always #5 clk = ~clk;

    pwm_capture4_if i0 ();
    pwm_capture4_if i1 ();
    pwm_capture4_if i2 ();
    pwm_capture4_if i3 ();

    assign i0.pwm = pwm[0];
    assign i1.pwm = pwm[1];
    assign i2.pwm = pwm[2];
    assign i3.pwm = pwm[3];

    duty_t duty [4];
    logic  vld  [4];
    logic  stk  [4];

    assign duty[0] = i0.duty;
    assign duty[1] = i1.duty;
    assign duty[2] = i2.duty;
    assign duty[3] = i3.duty;
    assign vld[0]  = i0.valid;
    assign vld[1]  = i1.valid;
    assign vld[2]  = i2.valid;
    assign vld[3]  = i3.valid;
    assign stk[0]  = i0.stuck;
    assign stk[1]  = i1.stuck;
    assign stk[2]  = i2.stuck;
    assign stk[3]  = i3.stuck;

    pwm_capture4 dut (
        .clk(clk), .rst(rst),
        .pwm_in_ch0(i0.pwm), .pwm_in_ch1(i1.pwm),
        .pwm_in_ch2(i2.pwm), .pwm_in_ch3(i3.pwm),
        .duty_ch0(i0.duty), .duty_ch1(i1.duty),
        .duty_ch2(i2.duty), .duty_ch3(i3.duty),
        .duty_valid_ch0(i0.valid), .duty_valid_ch1(i1.valid),
        .duty_valid_ch2(i2.valid), .duty_valid_ch3(i3.valid),
        .stuck_ch0(i0.stuck), .stuck_ch1(i1.stuck),
        .stuck_ch2(i2.stuck), .stuck_ch3(i3.stuck)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // generator configuration, written only by the tasks
    int hi [4];
    int lo [4];
    bit en [4];
    bit idle [4];
    int cfg_id [4];
    int disarm_id [4];

    int exp_q [4][$];
    int obs_d [4][$];
    int obs_c [4][$];

    // generators and monitor, all on the falling edge
    initial begin
        int gcnt [4];
        int cfg_seen [4];
        int disarm_seen [4];
        bit tb_arm [4];
        bit nxt;
        for (int c = 0; c < 4; c++) begin
            gcnt[c] = 0;
            cfg_seen[c] = 0;
            disarm_seen[c] = 0;
            tb_arm[c] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < 4; c++) begin
                if (vld[c] === 1'b1) begin
                    obs_d[c].push_back(int'(duty[c]));
                    obs_c[c].push_back(cyc);
                end
                if (cfg_seen[c] != cfg_id[c]) begin
                    cfg_seen[c] = cfg_id[c];
                    gcnt[c] = 0;
                end
                if (disarm_seen[c] != disarm_id[c]) begin
                    disarm_seen[c] = disarm_id[c];
                    tb_arm[c] = 1'b0;
                end
                nxt = en[c] ? (gcnt[c] < hi[c]) : idle[c];
                if (en[c]) begin
                    gcnt[c] = (gcnt[c] + 1 >= hi[c] + lo[c]) ? 0 : gcnt[c] + 1;
                end
                if (nxt && !pwm[c]) begin
                    if (tb_arm[c]) begin
                        exp_q[c].push_back(hi[c] > 255 ? 255 : hi[c]);
                    end
                    tb_arm[c] = 1'b1;
                end
                pwm[c] = nxt;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_gen(input int c, input int h, input int l);
        hi[c] = h;
        lo[c] = l;
        en[c] = 1'b1;
        cfg_id[c]++;
    endtask

    task automatic hold(input int c, input bit v);
        en[c] = 1'b0;
        idle[c] = v;
        cfg_id[c]++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            en[c] = 1'b0;
            idle[c] = 1'b0;
            cfg_id[c]++;
            disarm_id[c]++;
        end
        tick(3);
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            obs_d[c].delete();
            obs_c[c].delete();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (duty[c] !== 8'h00 || vld[c] !== 1'b0 || stk[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset ch%0d: duty=%0d valid=%b stuck=%b, required 0/0/0",
                         c, duty[c], vld[c], stk[c]);
            end
        end
        do_reset();
        tick(1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (duty[c] !== 8'h00 || vld[c] !== 1'b0 || stk[c] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset ch%0d: duty=%0d valid=%b stuck=%b, required 0/0/0",
                         c, duty[c], vld[c], stk[c]);
            end
        end
    endtask

    task automatic test_duty64();
        int e, o, oc, pc;
        do_reset();
        set_gen(0, 64, 192);
        tick(4 * 256 + 20);
        checks++;
        if (exp_q[0].size() != 4) begin
            errors++;
            $display("FAIL duty64_count: model queued %0d, required 4", exp_q[0].size());
        end
        pc = -1;
        while (exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            checks++;
            if (obs_d[0].size() == 0) begin
                errors++;
                $display("FAIL duty64: no valid pulse, required duty %0d", e);
            end else begin
                o = obs_d[0].pop_front();
                oc = obs_c[0].pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL duty64: duty=%0d, required %0d", o, e);
                end
                if (pc >= 0) begin
                    checks++;
                    if (oc - pc !== 256) begin
                        errors++;
                        $display("FAIL duty64_spacing: %0d cycles, required 256", oc - pc);
                    end
                end
                pc = oc;
            end
        end
        checks++;
        if (obs_d[0].size() != 0) begin
            errors++;
            $display("FAIL duty64_extra: %0d extra pulses, required 0", obs_d[0].size());
        end
    endtask

    task automatic test_multi();
        int e, o, oc, pc;
        do_reset();
        set_gen(1, 1, 255);
        set_gen(2, 128, 128);
        set_gen(3, 255, 1);
        tick(4 * 256 + 20);
        for (int c = 1; c < 4; c++) begin
            pc = -1;
            while (exp_q[c].size() > 0) begin
                e = exp_q[c].pop_front();
                checks++;
                if (obs_d[c].size() == 0) begin
                    errors++;
                    $display("FAIL multi ch%0d: no valid pulse, required duty %0d", c, e);
                end else begin
                    o = obs_d[c].pop_front();
                    oc = obs_c[c].pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL multi ch%0d: duty=%0d, required %0d", c, o, e);
                    end
                    if (pc >= 0) begin
                        checks++;
                        if (oc - pc !== 256) begin
                            errors++;
                            $display("FAIL multi_spacing ch%0d: %0d, required 256", c, oc - pc);
                        end
                    end
                    pc = oc;
                end
            end
            checks++;
            if (obs_d[c].size() != 0) begin
                errors++;
                $display("FAIL multi_extra ch%0d: %0d extra, required 0", c, obs_d[c].size());
            end
        end
    endtask

    task automatic test_timeout_low();
        int e, o;
        do_reset();
        for (int c = 0; c < 4; c++) exp_q[c].push_back(0);
        tick(500);
        checks++;
        if (obs_d[0].size() != 0 || stk[0] !== 1'b0) begin
            errors++;
            $display("FAIL early_timeout: pulses=%0d stuck=%b, required 0/0",
                     obs_d[0].size(), stk[0]);
        end
        tick(20);
        for (int c = 0; c < 4; c++) begin
            e = exp_q[c].pop_front();
            checks++;
            if (obs_d[c].size() != 1) begin
                errors++;
                $display("FAIL timeout_low ch%0d: %0d pulses, required 1", c, obs_d[c].size());
            end else begin
                o = obs_d[c].pop_front();
                void'(obs_c[c].pop_front());
                if (o !== e || stk[c] !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_low ch%0d: duty=%0d stuck=%b, required %0d/1",
                             c, o, stk[c], e);
                end
            end
        end
        tick(1500);
        checks++;
        if (obs_d[0].size() != 0 || stk[0] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_hold: pulses=%0d stuck=%b, required 0/1",
                     obs_d[0].size(), stk[0]);
        end
    endtask

    task automatic test_stuck_high();
        int e, o;
        do_reset();
        set_gen(2, 128, 128);
        tick(2 * 256 + 20);
        hold(2, 1'b1);
        disarm_id[2]++;
        exp_q[2].push_back(255);
        tick(2000);
        while (exp_q[2].size() > 0) begin
            e = exp_q[2].pop_front();
            checks++;
            if (obs_d[2].size() == 0) begin
                errors++;
                $display("FAIL stuck_high: no valid pulse, required duty %0d", e);
            end else begin
                o = obs_d[2].pop_front();
                void'(obs_c[2].pop_front());
                if (o !== e) begin
                    errors++;
                    $display("FAIL stuck_high: duty=%0d, required %0d", o, e);
                end
            end
        end
        checks++;
        if (obs_d[2].size() != 0 || stk[2] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_high_flag: extra=%0d stuck=%b, required 0/1",
                     obs_d[2].size(), stk[2]);
        end
        set_gen(2, 128, 128);
        tick(200);
        checks++;
        if (stk[2] !== 1'b1) begin
            errors++;
            $display("FAIL stuck_before_rise: stuck=%b, required 1", stk[2]);
        end
        tick(100);
        checks++;
        if (stk[2] !== 1'b0 || obs_d[2].size() != 0) begin
            errors++;
            $display("FAIL restart_arm: stuck=%b pulses=%0d, required 0/0",
                     stk[2], obs_d[2].size());
        end
        tick(260);
        checks++;
        if (exp_q[2].size() != 1 || obs_d[2].size() != 1) begin
            errors++;
            $display("FAIL restart: pulses=%0d, required %0d", obs_d[2].size(), exp_q[2].size());
        end else begin
            e = exp_q[2].pop_front();
            o = obs_d[2].pop_front();
            void'(obs_c[2].pop_front());
            if (o !== e) begin
                errors++;
                $display("FAIL restart: duty=%0d, required %0d", o, e);
            end
        end
    endtask

    task automatic test_irregular();
        int e, o, oc, pc, sp;
        do_reset();
        set_gen(3, 300, 50);
        set_gen(1, 10, 20);
        tick(1070);
        for (int c = 1; c < 4; c += 2) begin
            sp = (c == 1) ? 30 : 350;
            checks++;
            if (exp_q[c].size() != ((c == 1) ? 35 : 3)) begin
                errors++;
                $display("FAIL irregular_count ch%0d: model queued %0d", c, exp_q[c].size());
            end
            pc = -1;
            while (exp_q[c].size() > 0) begin
                e = exp_q[c].pop_front();
                checks++;
                if (obs_d[c].size() == 0) begin
                    errors++;
                    $display("FAIL irregular ch%0d: no valid pulse, required duty %0d", c, e);
                end else begin
                    o = obs_d[c].pop_front();
                    oc = obs_c[c].pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL irregular ch%0d: duty=%0d, required %0d", c, o, e);
                    end
                    if (pc >= 0) begin
                        checks++;
                        if (oc - pc !== sp) begin
                            errors++;
                            $display("FAIL irregular_spacing ch%0d: %0d, required %0d",
                                     c, oc - pc, sp);
                        end
                    end
                    pc = oc;
                end
            end
            checks++;
            if (obs_d[c].size() != 0) begin
                errors++;
                $display("FAIL irregular_extra ch%0d: %0d, required 0", c, obs_d[c].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int e, o;
        do_reset();
        set_gen(1, 100, 156);
        tick(2 * 256 + 150);
        checks++;
        if (duty[1] !== 8'd100 || obs_d[1].size() != 2) begin
            errors++;
            $display("FAIL pre_reset: duty=%0d pulses=%0d, required 100/2",
                     duty[1], obs_d[1].size());
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (duty[1] !== 8'h00 || vld[1] !== 1'b0 || stk[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: duty=%0d valid=%b stuck=%b, required 0/0/0",
                     duty[1], vld[1], stk[1]);
        end
        disarm_id[1]++;
        tick(3);
        exp_q[1].delete();
        obs_d[1].delete();
        obs_c[1].delete();
        rst = 1'b0;
        tick(400);
        checks++;
        if (exp_q[1].size() != 1 || obs_d[1].size() != 1) begin
            errors++;
            $display("FAIL reset_rearm: pulses=%0d, required %0d", obs_d[1].size(), exp_q[1].size());
        end else begin
            e = exp_q[1].pop_front();
            o = obs_d[1].pop_front();
            void'(obs_c[1].pop_front());
            if (o !== e) begin
                errors++;
                $display("FAIL reset_rearm: duty=%0d, required %0d", o, e);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            hi[c] = 0;
            lo[c] = 0;
            en[c] = 1'b0;
            idle[c] = 1'b0;
            cfg_id[c] = 0;
            disarm_id[c] = 0;
        end
        test_reset();
        test_duty64();
        test_multi();
        test_timeout_low();
        test_stuck_high();
        test_irregular();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_capture4.md
Name: pwm_capture4

Overview:
- Four-channel PWM duty-cycle decoder; the receive-side counterpart of the team's 4-channel PWM generator.
- Measures the high time of each incoming PWM waveform over one period (rising edge to rising edge).
- Reports an 8-bit duty value per channel, matching the generator's encoding: duty N = N high cycles in a 256-cycle period.
- Used for loopback self-test of the generator and for capturing external PWM inputs.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per input (minimum 2).
- TIMEOUT, 511, cycles without a rising edge before a channel is declared stuck (must be less than 2^CNT_W).
- CNT_W, 10, width of the internal period and high-time counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pwm_in_ch0..pwm_in_ch3  input  1 each  PWM inputs, asynchronous to clk.
- duty_ch0..duty_ch3  output  8 each  last measured duty per channel.
- duty_valid_ch0..duty_valid_ch3  output  1 each  one-cycle pulse when the matching duty_chN updates.
- stuck_ch0..stuck_ch3  output  1 each  high while the channel is in timeout.

Behaviour:
- Clocking and reset:
  - One clock domain (clk). Reset is asynchronous and active-high on rst.
  - All flops clear on reset: synchronizers, counters, armed flags and outputs.
  - Output reset values: duty = 0, duty_valid = 0, stuck = 0.
- Input stage:
  - Each input passes through a SYNC_STAGES flop chain, giving s.
  - s_d is a one-cycle-delayed copy of s. rise = s & ~s_d.
- Per-channel registers: period_cnt (CNT_W bits), high_acc (CNT_W bits), armed (1 bit).
- On a rise cycle:
  - If armed = 1: duty <= min(high_acc, 255), duty_valid <= 1.
  - In all cases: high_acc <= 1, period_cnt <= 1, armed <= 1, stuck <= 0.
- On a non-rise cycle:
  - period_cnt <= period_cnt + 1, saturating at all-ones.
  - high_acc <= high_acc + s, saturating at all-ones.
  - duty_valid <= 0.
- First rising edge after reset or after a timeout only arms the channel. No duty is reported for the partial period.
- Timeout:
  - Trigger: period_cnt == TIMEOUT and no rise in the same cycle.
  - Actions: duty <= (s ? 8'hFF : 8'h00), duty_valid <= 1 (one pulse), stuck <= 1, armed <= 0, period_cnt <= 0, high_acc <= 0.
  - While stuck: no further timeout pulses until the next rise. Implement with a stuck-hold: period_cnt does not count while stuck = 1.
- Latency:
  - Pin edge to rise: SYNC_STAGES + 1 cycles.
  - duty and duty_valid are registered and change on the cycle after rise.
- Period length is not checked. Any rising-edge-to-rising-edge interval shorter than TIMEOUT is accepted, and high time above 255 saturates to 255.
- A glitch shorter than one clk may be missed entirely. This is acceptable.
- Reset asserted mid-period: all state clears immediately, and the next rise only arms the channel.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Decomposition:
- Shared package pwm_pkg:
  - DUTY_W = 8, PWM_PERIOD = 256, default TIMEOUT, DUTY_MAX = 8'hFF.
  - The generator uses the same constants.
- Sub-module pwm_capture_ch:
  - Contents: synchronizer, edge detect, counters, armed/stuck logic and output registers for one channel.
  - pwm_capture4 instantiates it four times. The top level contains no logic.

Test Plan:
- Reset, then drive the generator with duty 64 looped into ch0 -> first rise produces no duty_valid; every following period gives one duty_valid pulse with duty_ch0 = 64 (0x40), 256 cycles apart.
- Duty values 1, 128 and 255 on ch1..ch3 simultaneously -> duty_ch1 = 1, duty_ch2 = 128, duty_ch3 = 255 each period; valids pulse independently.
- ch0 held at 0 after reset -> 511 cycles after the last rise (or after reset-armed state) no valid; then a single timeout pulse with duty_ch0 = 0 and stuck_ch0 = 1, and no further pulses.
- ch2 held high for 2000 cycles after valid operation -> one timeout pulse with duty_ch2 = 255 and stuck_ch2 = 1; on restart, stuck clears at the first rise and the next valid duty is reported one period later.
- Irregular input (high 300, low 50) -> duty saturates to 255; high 10, low 20 -> duty = 10 with a valid every 30 cycles.
- rst asserted mid-period on ch1 (duty 100) -> outputs go to 0 immediately and asynchronously; after release, the first rise is not reported and the second gives 100.
